// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard front end.
//   PS2_PFX_EXT / PS2_PFX_BRK / PS2_PFX_PAUSE : scan-code prefix bytes
//   PS2_PAUSE_LEN : total byte count of the PAUSE key sequence
//   frame_state_t : serial frame receiver states
//   ps2_key_t     : 65-bit event word ([64] toggle, [63:0] byte history)
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam int         PS2_PAUSE_LEN = 8;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    typedef logic [64:0] ps2_key_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 serial frame receiver.
//   Synchronizes ps2_clk/ps2_dat, deglitches the clock, samples data on
//   filtered falling edges and checks start/parity/stop. A frame that stalls
//   for TIMEOUT_CYC cycles between falling edges is aborted.
// Ports:
//   CLK, RESET        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   rx_byte           last accepted byte (valid with byte_stb)
//   byte_stb          one-cycle pulse per good frame
//   rx_err            one-cycle pulse on parity, stop or timeout error
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a falling edge
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing parity bit, odd parity evaluated
// STOP   | expecting stop bit = 1, then byte_stb or rx_err
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          dat_smp;

    // Down-counter counts consecutive samples that disagree with the filtered
    // level; the level flips on the FILTER_LEN-th one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= FILT_LOAD;
            fall     <= 1'b0;
            dat_smp  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= FILT_LOAD;
            end else if (filt_cnt == '0) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= FILT_LOAD;
                fall     <= clk_filt;
                dat_smp  <= dat_sync[1];
            end else begin
                filt_cnt <= filt_cnt - 1'b1;
            end
        end
    end

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            to_cnt   <= TO_LOAD;
            rx_byte  <= '0;
            byte_stb <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            rx_err   <= 1'b0;
            // An edge always takes priority over an expiring timeout.
            if (fall) begin
                to_cnt <= TO_LOAD;
                case (state)
                    IDLE: begin
                        if (!dat_smp) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_smp, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{shreg, dat_smp};
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat_smp && par_ok) begin
                            rx_byte  <= shreg;
                            byte_stb <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == '0) begin
                    state  <= IDLE;
                    rx_err <= 1'b1;
                    to_cnt <= TO_LOAD;
                end else begin
                    to_cnt <= to_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_gen.sv
// ps2_key_gen: builds the 65-bit ps2_key event word from a PS/2 keyboard.
//   Bytes from ps2_frame_rx are collected into a sequence (prefixes E0/F0
//   keep it open, E1 opens an 8-byte PAUSE sequence). When a sequence closes
//   the last 8 bytes are published on ps2_key[63:0] and ps2_key[64] toggles.
// Optional macro PS2_REPEAT_SUPPRESS_EN: drops typematic repeats of the
//   most recent make code (break events re-arm it; PAUSE never suppressed).
// Ports:
//   CLK, RESET        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   ps2_key           [64] event toggle, [63:0] byte history (newest [7:0])
//   byte_stb          one-cycle pulse per accepted byte
//   rx_err            one-cycle pulse on parity, stop or timeout error
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     ps2_clk,
    input  logic     ps2_dat,
    output ps2_key_t ps2_key,
    output logic     byte_stb,
    output logic     rx_err
);

    logic [7:0] rx_byte;
    logic       rx_stb;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .CLK      (CLK),
        .RESET    (RESET),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .byte_stb (rx_stb),
        .rx_err   (rx_err)
    );

    assign byte_stb = rx_stb;

    logic [63:0] hist;
    logic        seq_open;
    logic        pause_mode;
    logic [3:0]  seq_len;

    logic [63:0] hist_nxt;
    logic [3:0]  len_nxt;
    logic        pause_nxt;
    logic        close;
    logic        emit;

`ifdef PS2_REPEAT_SUPPRESS_EN
    logic [8:0] last_make;
    logic       last_valid;
    logic       ext_nxt;
    logic       brk_nxt;
    logic       seq_ext;
    logic       seq_brk;
`endif

    always_comb begin
        hist_nxt  = seq_open ? {hist[55:0], rx_byte} : {56'd0, rx_byte};
        len_nxt   = !seq_open ? 4'd1 : ((seq_len == 4'hF) ? seq_len : seq_len + 4'd1);
        pause_nxt = (seq_open && pause_mode) || (rx_byte == PS2_PFX_PAUSE);
        close     = pause_nxt ? (len_nxt >= 4'(PS2_PAUSE_LEN)) : !is_prefix(rx_byte);
        emit      = 1'b1;
`ifdef PS2_REPEAT_SUPPRESS_EN
        ext_nxt = (seq_open && seq_ext) || (rx_byte == PS2_PFX_EXT);
        brk_nxt = (seq_open && seq_brk) || (rx_byte == PS2_PFX_BRK);
        if (!pause_nxt && !brk_nxt && last_valid && (last_make == {ext_nxt, rx_byte}))
            emit = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hist       <= '0;
            seq_open   <= 1'b0;
            pause_mode <= 1'b0;
            seq_len    <= '0;
            ps2_key    <= '0;
`ifdef PS2_REPEAT_SUPPRESS_EN
            last_make  <= '0;
            last_valid <= 1'b0;
            seq_ext    <= 1'b0;
            seq_brk    <= 1'b0;
`endif
        end else if (rx_stb) begin
            hist <= hist_nxt;
            if (close) begin
                seq_open   <= 1'b0;
                pause_mode <= 1'b0;
                seq_len    <= '0;
                if (emit) ps2_key <= {~ps2_key[64], hist_nxt};
`ifdef PS2_REPEAT_SUPPRESS_EN
                seq_ext <= 1'b0;
                seq_brk <= 1'b0;
                if (!pause_nxt) begin
                    if (brk_nxt) begin
                        last_valid <= 1'b0;
                    end else begin
                        last_make  <= {ext_nxt, rx_byte};
                        last_valid <= 1'b1;
                    end
                end
`endif
            end else begin
                seq_open   <= 1'b1;
                pause_mode <= pause_nxt;
                seq_len    <= len_nxt;
`ifdef PS2_REPEAT_SUPPRESS_EN
                seq_ext <= ext_nxt;
                seq_brk <= brk_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_gen.sv
module tb_ps2_key_gen;
    import ps2_pkg::*;

    localparam int H = 12;   // half bit period in CLK cycles

    logic     CLK = 1'b0;
    logic     RESET = 1'b1;
    logic     ps2_clk = 1'b1;
    logic     ps2_dat = 1'b1;
    ps2_key_t ps2_key;
    logic     byte_stb;
    logic     rx_err;

    ps2_key_gen dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .ps2_key  (ps2_key),
        .byte_stb (byte_stb),
        .rx_err   (rx_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    int stb_seen = 0;
    int toggles = 0;
    int key_fail_prints = 0;
    logic prev_tog = 1'b0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] seq[$];
    ps2_key_t   exp_key = '0;
    logic       last_valid = 1'b0;
    logic [8:0] last_make = '0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_key    = '0;
        seq.delete();
        exp_q.delete();
        last_valid = 1'b0;
        last_make  = '0;
    endtask

    // Sequence rules applied to one accepted byte.
    task automatic model_byte(input logic [7:0] b);
        bit          pause = 0;
        bit          ext = 0;
        bit          brk = 0;
        bit          closes;
        bit          emit = 1;
        logic [63:0] h = '0;
        seq.push_back(b);
        foreach (seq[i]) begin
            if (seq[i] == 8'hE1) pause = 1;
            if (seq[i] == 8'hE0) ext = 1;
            if (seq[i] == 8'hF0) brk = 1;
        end
        if (pause) closes = (seq.size() >= 8);
        else       closes = !(b == 8'hE0 || b == 8'hF0);
        if (closes) begin
            foreach (seq[i]) h = {h[55:0], seq[i]};
`ifdef PS2_REPEAT_SUPPRESS_EN
            if (!pause) begin
                if (brk) last_valid = 1'b0;
                else if (last_valid && last_make == {ext, b}) emit = 0;
                else begin
                    last_make  = {ext, b};
                    last_valid = 1'b1;
                end
            end
`endif
            if (emit) exp_key = {~exp_key[64], h};
            seq.delete();
        end
    endtask

    // Per-cycle compare against the model; ps2_key lags byte_stb by one cycle,
    // so the model advances after this cycle's comparison.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_tog = ps2_key[64];
        end else begin
            checks++;
            if (ps2_key !== exp_key) begin
                errors++;
                if (key_fail_prints < 10) begin
                    key_fail_prints++;
                    $display("FAIL ps2_key_cycle: got %h expected %h at %0t", ps2_key, exp_key, $time);
                end
            end
            if (ps2_key[64] !== prev_tog) toggles++;
            prev_tog = ps2_key[64];
            if (rx_err) err_seen++;
            if (byte_stb) begin
                stb_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_stb_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    model_byte(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            cyc(H);
            ps2_clk = 1'b0;
            cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        if (!bad_par && !bad_stop) exp_q.push_back(b);
        else err_exp++;
        send_bits(bits, 11);
        cyc(30);
        check("byte_q_drained", 65'(exp_q.size()), 65'd0);
        check("err_count", 65'(err_seen), 65'(err_exp));
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        cyc(4);
        RESET = 1'b0;
        cyc(2);
    endtask

    initial begin
        int t0;
        int s0;
        logic [7:0] prev_code;
        prev_code = 8'h1C;

        cyc(5);
        RESET = 1'b0;
        cyc(2);
        check("reset_key", ps2_key, 65'd0);
        check("reset_stb", 65'(byte_stb), 65'd0);
        check("reset_err", 65'(rx_err), 65'd0);

        // Single make code
        t0 = toggles; s0 = stb_seen;
        good(8'h1C);
        check("t1_key", ps2_key, {1'b1, 56'd0, 8'h1C});
        check("t1_toggles", 65'(toggles - t0), 65'd1);
        check("t1_stb", 65'(stb_seen - s0), 65'd1);

        // Extended break: one event for three bytes
        t0 = toggles; s0 = stb_seen;
        good(8'hE0); good(8'hF0); good(8'h75);
        check("ext_brk_key", ps2_key, {1'b0, 40'd0, 24'hE0F075});
        check("ext_brk_toggles", 65'(toggles - t0), 65'd1);
        check("ext_brk_stb", 65'(stb_seen - s0), 65'd3);

        // Parity error then good retry
        t0 = toggles;
        send_frame(8'h29, 1'b1, 1'b0);
        check("par_err_key_held", ps2_key, {1'b0, 40'd0, 24'hE0F075});
        check("par_err_toggles", 65'(toggles - t0), 65'd0);
        good(8'h29);
        check("retry_29", 65'(ps2_key[7:0]), 65'h29);

        // Timeout after 4 data bits, then a clean frame
        err_exp++;
        send_bits({1'b1, 1'b1, 8'h14, 1'b0}, 5);
        cyc(48100);
        check("timeout_err", 65'(err_seen), 65'(err_exp));
        good(8'h14);
        check("after_timeout_14", 65'(ps2_key[7:0]), 65'h14);

        // Short clock glitches in IDLE must be invisible
        t0 = toggles; s0 = stb_seen;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0; cyc(2);
            ps2_clk = 1'b1; cyc(20);
        end
        check("glitch_err", 65'(err_seen), 65'(err_exp));
        check("glitch_stb", 65'(stb_seen - s0), 65'd0);
        check("glitch_toggles", 65'(toggles - t0), 65'd0);

        // PAUSE sequence
        t0 = toggles;
        good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
        good(8'hF0); good(8'h14); good(8'hF0); good(8'h77);
        check("pause_key", 65'(ps2_key[63:0]), 65'hE11477E1F014F077);
        check("pause_toggles", 65'(toggles - t0), 65'd1);

        // Reset in the middle of a sequence
        good(8'hF0);
        do_reset();
        check("mid_reset_key", ps2_key, 65'd0);
        t0 = toggles;
        good(8'h1C);
        check("post_reset_key", ps2_key, {1'b1, 56'd0, 8'h1C});
        check("post_reset_lo16", 65'(ps2_key[15:0]), 65'h001C);

        // Typematic repeats
        do_reset();
        t0 = toggles;
        good(8'h1C); good(8'h1C); good(8'h1C);
        good(8'hF0); good(8'h1C); good(8'h1C);
`ifdef PS2_REPEAT_SUPPRESS_EN
        check("repeat_toggles", 65'(toggles - t0), 65'd3);
`else
        check("repeat_toggles", 65'(toggles - t0), 65'd5);
`endif

        // Randomized traffic including frame errors
        for (int n = 0; n < 40; n++) begin
            int r;
            int rb;
            logic [7:0] b;
            r  = int'($urandom_range(0, 99));
            rb = int'($urandom_range(0, 99));
            if (rb < 15)      b = 8'hE0;
            else if (rb < 30) b = 8'hF0;
            else if (rb < 50) b = prev_code;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) b = 8'h1C;
            end
            if (!(b == 8'hE0 || b == 8'hF0)) prev_code = b;
            if (r < 10)      send_frame(b, 1'b1, 1'b0);
            else if (r < 15) send_frame(b, 1'b0, 1'b1);
            else             good(b);
        end

        cyc(10);
        check("final_err_count", 65'(err_seen), 65'(err_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
